// File: rtl/axis_ddr_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axis_ddr_chk_pkg                                       |
// | Description : Shared types, defaults and helpers for the DDR         |
// |               read-back checker.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package axis_ddr_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } chk_state_t;

    localparam int DEFAULT_TIMEOUT = 4096;

    // Widest counter the saturating helper supports.
    localparam int SAT_MAX_W = 64;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] max_val;
        if (width >= SAT_MAX_W)
            max_val = '1;
        else
            max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        return (value == max_val) ? value : value + SAT_MAX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_ready_throttle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axis_ready_throttle                                    |
// | Description : Registered tready generator. After every accepted beat |
// |               ready drops for exactly 'gap' cycles.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axis_ready_throttle (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       accept,
    input  logic [7:0] gap,
    output logic       ready
);

    logic [7:0] gap_left;

    // Ready register plus countdown of remaining low cycles after an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready    <= 1'b0;
            gap_left <= 8'd0;
        end else if (!enable) begin
            ready    <= 1'b0;
            gap_left <= 8'd0;
        end else if (accept && (gap != 8'd0)) begin
            ready    <= 1'b0;
            gap_left <= gap;
        end else if (gap_left != 8'd0) begin
            gap_left <= gap_left - 8'd1;
            ready    <= (gap_left == 8'd1);
        end else begin
            ready    <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_ddr_rd_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : axis_ddr_rd_checker                                    |
// | Description : AXIS read-back consumer. Checks an incrementing        |
// |               pattern, counts errors and measures throughput.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module axis_ddr_rd_checker
    import axis_ddr_chk_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_WIDTH-1:0]    nbeats,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic [7:0]              ready_gap,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [CNT_WIDTH-1:0]    first_err_idx,
    output logic [DATA_WIDTH-1:0]   first_err_data,
    output logic [CNT_WIDTH-1:0]    cycle_cnt,
    output logic [CNT_WIDTH-1:0]    tlast_cnt
);

    localparam int IDLE_WIDTH = $clog2(TIMEOUT + 1);

    chk_state_t              state;
    chk_state_t              state_next;
    logic [CNT_WIDTH-1:0]    nbeats_q;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [7:0]              gap_q;
    logic [IDLE_WIDTH-1:0]   idle_cnt;

    logic                    accept;
    logic                    start_go;
    logic                    last_beat;
    logic                    idle_expired;
    logic                    mismatch;
    logic [DATA_WIDTH-1:0]   expected;
    logic                    throttle_en;

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        return CNT_WIDTH'(sat_inc(SAT_MAX_W'(v), CNT_WIDTH));
    endfunction

    assign busy         = (state == ST_WAIT_FIRST) || (state == ST_RUN);
    assign done         = (state == ST_DONE);
    assign accept       = s_axis_tvalid && s_axis_tready && busy;
    assign start_go     = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_beat    = (beat_cnt == nbeats_q - CNT_WIDTH'(1));
    assign idle_expired = (idle_cnt == IDLE_WIDTH'(TIMEOUT - 1));
    assign expected     = seed_q + DATA_WIDTH'(beat_cnt);
    assign mismatch     = (s_axis_tdata != expected) || (s_axis_tstrb != '1);
    assign throttle_en  = (state_next == ST_WAIT_FIRST) || (state_next == ST_RUN);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start)
                        state_next = (nbeats == '0) ? ST_DONE : ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST, ST_RUN: begin
                    if (accept)
                        state_next = last_beat ? ST_DONE : ST_RUN;
                    else if (idle_expired)
                        state_next = ST_DONE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Run configuration latch, beat checking and status counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            nbeats_q       <= '0;
            seed_q         <= '0;
            gap_q          <= '0;
            idle_cnt       <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            beat_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            cycle_cnt      <= '0;
            tlast_cnt      <= '0;
        end else if (abort) begin
            // Counters keep their values for readout; pass only means something in DONE.
            pass <= 1'b0;
        end else if (start_go) begin
            nbeats_q       <= nbeats;
            seed_q         <= seed;
            gap_q          <= ready_gap;
            idle_cnt       <= '0;
            pass           <= (nbeats == '0);
            timeout        <= 1'b0;
            beat_cnt       <= '0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            cycle_cnt      <= '0;
            tlast_cnt      <= '0;
        end else if (busy) begin
            if (state == ST_WAIT_FIRST) begin
                if (accept)
                    cycle_cnt <= CNT_WIDTH'(1);
            end else begin
                cycle_cnt <= cnt_inc(cycle_cnt);
            end

            if (accept) begin
                idle_cnt <= '0;
                beat_cnt <= cnt_inc(beat_cnt);
                if (s_axis_tlast)
                    tlast_cnt <= cnt_inc(tlast_cnt);
                if (mismatch) begin
                    err_cnt <= cnt_inc(err_cnt);
                    if (err_cnt == '0) begin
                        first_err_idx  <= beat_cnt;
                        first_err_data <= s_axis_tdata;
                    end
                end
                if (last_beat)
                    pass <= !mismatch && (err_cnt == '0);
            end else begin
                idle_cnt <= idle_cnt + IDLE_WIDTH'(1);
                if (idle_expired) begin
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end
            end
        end
    end

    axis_ready_throttle u_throttle (
        .clk    (aclk),
        .rst_n  (aresetn),
        .enable (throttle_en),
        .accept (accept),
        .gap    (gap_q),
        .ready  (s_axis_tready)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_ddr_rd_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_axis_ddr_rd_checker                                 |
// | Description : Self-checking bench for axis_ddr_rd_checker.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_axis_ddr_rd_checker;

    localparam int DW  = 64;
    localparam int CW  = 32;
    localparam int TMO = 64;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [CW-1:0]  nbeats = '0;
    logic [DW-1:0]  seed = '0;
    logic [7:0]     ready_gap = '0;
    logic           s_axis_tvalid = 1'b0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic [DW/8-1:0] s_axis_tstrb = '0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_tready;
    logic           busy, done, pass, timeout;
    logic [CW-1:0]  beat_cnt, err_cnt, first_err_idx, cycle_cnt, tlast_cnt;
    logic [DW-1:0]  first_err_data;

    typedef struct {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } beat_t;

    typedef struct {
        int            beats;
        int            errs;
        int            fidx;
        logic [DW-1:0] fdata;
        int            cycles;   // negative: not checked
        int            tlasts;
        bit            tmo;
        bit            pass;
    } exp_t;

    beat_t src_q[$];
    exp_t  sb[$];
    int    acc_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    axis_ddr_rd_checker #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .TIMEOUT    (TMO)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .start          (start),
        .abort          (abort),
        .nbeats         (nbeats),
        .seed           (seed),
        .ready_gap      (ready_gap),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .beat_cnt       (beat_cnt),
        .err_cnt        (err_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data),
        .cycle_cnt      (cycle_cnt),
        .tlast_cnt      (tlast_cnt)
    );

    always #5 aclk = ~aclk;

    // Free-running edge counter used to time accepts.
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_start(input int n, input logic [DW-1:0] s, input int g);
        nbeats    = CW'(n);
        seed      = s;
        ready_gap = 8'(g);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Build an incrementing stream with optional corrupt data / strobe beats.
    task automatic fill_src(input int n, input logic [DW-1:0] s, input int bad_idx,
                            input logic [DW-1:0] bad_data, input int strb_idx);
        beat_t b;
        src_q.delete();
        for (int i = 0; i < n; i++) begin
            b.data = s + DW'(i);
            if (i == bad_idx) b.data = bad_data;
            b.strb = (i == strb_idx) ? 8'h7F : 8'hFF;
            b.last = (i == n - 1);
            src_q.push_back(b);
        end
    endtask

    // Source: keeps tvalid high and records the edge of every accepted beat.
    task automatic send_beats(input int n);
        int    sent;
        int    guard;
        logic  rdy;
        beat_t b;
        sent  = 0;
        guard = 0;
        acc_cyc.delete();
        while (sent < n && guard < 2000 && src_q.size() > 0) begin
            b = src_q[0];
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b.data;
            s_axis_tstrb  = b.strb;
            s_axis_tlast  = b.last;
            rdy = s_axis_tready;
            step();
            guard++;
            if (rdy) begin
                acc_cyc.push_back(cyc);
                void'(src_q.pop_front());
                sent++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL send_beats: accepted %0d beats, required %0d", sent, n);
        end
    endtask

    // Wait for DONE and compare the status against the oldest scoreboard entry.
    task automatic finish_run(input string name);
        exp_t e;
        int   guard;
        guard = 0;
        while (!done && guard < TMO + 50) begin
            step();
            guard++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b, expected 1", name, done);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue, expected one entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (pass !== e.pass) begin
                errors++;
                $display("FAIL %s pass: got %b, expected %b", name, pass, e.pass);
            end
            checks++;
            if (timeout !== e.tmo) begin
                errors++;
                $display("FAIL %s timeout: got %b, expected %b", name, timeout, e.tmo);
            end
            checks++;
            if (beat_cnt !== CW'(e.beats)) begin
                errors++;
                $display("FAIL %s beat_cnt: got %0d, expected %0d", name, beat_cnt, e.beats);
            end
            checks++;
            if (err_cnt !== CW'(e.errs)) begin
                errors++;
                $display("FAIL %s err_cnt: got %0d, expected %0d", name, err_cnt, e.errs);
            end
            checks++;
            if (first_err_idx !== CW'(e.fidx)) begin
                errors++;
                $display("FAIL %s first_err_idx: got %0d, expected %0d", name, first_err_idx, e.fidx);
            end
            checks++;
            if (first_err_data !== e.fdata) begin
                errors++;
                $display("FAIL %s first_err_data: got %h, expected %h", name, first_err_data, e.fdata);
            end
            checks++;
            if (tlast_cnt !== CW'(e.tlasts)) begin
                errors++;
                $display("FAIL %s tlast_cnt: got %0d, expected %0d", name, tlast_cnt, e.tlasts);
            end
            if (e.cycles >= 0) begin
                checks++;
                if (cycle_cnt !== CW'(e.cycles)) begin
                    errors++;
                    $display("FAIL %s cycle_cnt: got %0d, expected %0d", name, cycle_cnt, e.cycles);
                end
            end
            checks++;
            if (s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL %s tready_in_done: got %b, expected 0", name, s_axis_tready);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({s_axis_tready, busy, done, pass, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b, expected 00000",
                     {s_axis_tready, busy, done, pass, timeout});
        end
        checks++;
        if ({beat_cnt, err_cnt, cycle_cnt, tlast_cnt, first_err_idx} !== '0 || first_err_data !== '0) begin
            errors++;
            $display("FAIL reset counters: got beat=%0d err=%0d cyc=%0d, expected all 0",
                     beat_cnt, err_cnt, cycle_cnt);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        fill_src(100, '0, -1, '0, -1);
        sb.push_back('{beats: 100, errs: 0, fidx: 0, fdata: '0, cycles: 100, tlasts: 1, tmo: 1'b0, pass: 1'b1});
        do_start(100, '0, 0);
        send_beats(100);
        finish_run("basic");
    endtask

    task automatic test_data_error();
        fill_src(10, 64'd5, 3, 64'hDEAD, -1);
        sb.push_back('{beats: 10, errs: 1, fidx: 3, fdata: 64'hDEAD, cycles: 10, tlasts: 1, tmo: 1'b0, pass: 1'b0});
        do_start(10, 64'd5, 0);
        send_beats(10);
        finish_run("data_error");
    endtask

    task automatic test_strobe_error();
        fill_src(3, 64'd100, -1, '0, 1);
        sb.push_back('{beats: 3, errs: 1, fidx: 1, fdata: 64'd101, cycles: 3, tlasts: 1, tmo: 1'b0, pass: 1'b0});
        do_start(3, 64'd100, 0);
        send_beats(3);
        finish_run("strobe_error");
    endtask

    task automatic test_wrap();
        fill_src(4, 64'hFFFF_FFFF_FFFF_FFFE, -1, '0, -1);
        sb.push_back('{beats: 4, errs: 0, fidx: 0, fdata: '0, cycles: 4, tlasts: 1, tmo: 1'b0, pass: 1'b1});
        do_start(4, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        send_beats(4);
        finish_run("wrap");
    endtask

    task automatic test_gap();
        fill_src(8, 64'd7, -1, '0, -1);
        sb.push_back('{beats: 8, errs: 0, fidx: 0, fdata: '0, cycles: 29, tlasts: 1, tmo: 1'b0, pass: 1'b1});
        do_start(8, 64'd7, 3);
        send_beats(8);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
                errors++;
                $display("FAIL gap interval[%0d]: got %0d cycles, expected 4", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        finish_run("gap");
    endtask

    task automatic test_timeout();
        int last_acc;
        int waited;
        fill_src(10, 64'd0, -1, '0, -1);
        sb.push_back('{beats: 6, errs: 0, fidx: 0, fdata: '0, cycles: -1, tlasts: 0, tmo: 1'b1, pass: 1'b0});
        do_start(10, 64'd0, 0);
        send_beats(6);
        last_acc = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] : cyc;
        finish_run("timeout");
        waited = cyc - last_acc;
        checks++;
        if (waited < TMO || waited > TMO + 1) begin
            errors++;
            $display("FAIL timeout latency: got %0d cycles, expected %0d..%0d", waited, TMO, TMO + 1);
        end
    endtask

    task automatic test_zero_beats();
        sb.push_back('{beats: 0, errs: 0, fidx: 0, fdata: '0, cycles: 0, tlasts: 0, tmo: 1'b0, pass: 1'b1});
        do_start(0, 64'd9, 0);
        finish_run("zero_beats");
    endtask

    task automatic test_abort_restart();
        fill_src(10, 64'd0, -1, '0, -1);
        do_start(10, 64'd0, 0);
        send_beats(4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({busy, done, s_axis_tready} !== 3'b000) begin
            errors++;
            $display("FAIL abort state: got busy/done/tready=%b, expected 000", {busy, done, s_axis_tready});
        end
        checks++;
        if (beat_cnt !== 32'd4) begin
            errors++;
            $display("FAIL abort beat_cnt: got %0d, expected 4", beat_cnt);
        end
        // A start with a simultaneous abort must be ignored.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || beat_cnt !== 32'd4) begin
            errors++;
            $display("FAIL start_with_abort: got busy=%b beat_cnt=%0d, expected 0 and 4", busy, beat_cnt);
        end
        fill_src(2, 64'd50, -1, '0, -1);
        sb.push_back('{beats: 2, errs: 0, fidx: 0, fdata: '0, cycles: 2, tlasts: 1, tmo: 1'b0, pass: 1'b1});
        do_start(2, 64'd50, 0);
        checks++;
        if (beat_cnt !== 32'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart clear: got beat_cnt=%0d busy=%b, expected 0 and 1", beat_cnt, busy);
        end
        send_beats(2);
        finish_run("restart");
    endtask

    task automatic test_reset_midrun();
        fill_src(10, 64'd0, -1, '0, -1);
        do_start(10, 64'd0, 0);
        send_beats(3);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, s_axis_tready, pass, timeout} !== 5'b0 || beat_cnt !== '0 || cycle_cnt !== '0) begin
            errors++;
            $display("FAIL reset_midrun: got flags=%b beat_cnt=%0d cycle_cnt=%0d, expected all 0",
                     {busy, done, s_axis_tready, pass, timeout}, beat_cnt, cycle_cnt);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_data_error();
        test_strobe_error();
        test_wrap();
        test_gap();
        test_timeout();
        test_zero_beats();
        test_abort_restart();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
